acc16_seq: RTL and testbench

Sequential accumulator wrapped around the 16-bit ripple-carry adder datapath. Accepts a stream of 16-bit operands with opcodes over a valid/ready handshake and folds each one into a registered accumulator (add, subtract, load, clear). Presents the result with carry/overflow/zero flags over a second valid/ready handshake. Sits directly downstream of the `fulladder16` adder, instantiating it as its only arithmetic element and registering what it produces.

---
 rtl/acc16_seq.sv | 156 +++++++++++++++
 tb/tb_acc16_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc16_seq.sv
// Sequential accumulator around a 16-bit ripple-carry adder, with valid/ready on both sides.
// Optional saturating arithmetic is enabled by defining ACC16_SAT_EN.

module fulladder16 (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] Sum,
    output logic        Cout
);
    logic [16:0] w_c;

    assign w_c[0] = Cin;

    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign Sum[i]    = A[i] ^ B[i] ^ w_c[i];
        assign w_c[i+1]  = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end

    assign Cout = w_c[16];
endmodule

module acc16_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] In,
    input  logic [1:0]  Op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Acc,
    output logic        Cout,
    output logic        Ovf,
    output logic        OvfSticky,
    output logic        Zero,
    output logic [7:0]  Count
);
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_accept;

    logic [15:0] r_acc;
    logic        r_cout;
    logic        r_ovf;
    logic        r_ovf_sticky;
    logic        r_zero;
    logic [7:0]  r_count;

    logic        w_is_sub;
    logic [15:0] w_b;
    logic [15:0] w_sum;
    logic        w_cout;
    logic        w_ovf;
    logic [15:0] w_acc_arith;

`ifdef ACC16_SAT_EN
    // Clamp direction follows the sign of the accumulator operand.
    function automatic logic [15:0] sat16(input logic neg);
        return neg ? 16'h8000 : 16'h7FFF;
    endfunction
`endif

    assign w_is_sub = (Op == OP_SUB);
    assign w_b      = w_is_sub ? ~In : In;

    fulladder16 u_add (
        .A    (r_acc),
        .B    (w_b),
        .Cin  (w_is_sub),
        .Sum  (w_sum),
        .Cout (w_cout)
    );

    assign w_ovf = (r_acc[15] == w_b[15]) && (w_sum[15] != r_acc[15]);

`ifdef ACC16_SAT_EN
    assign w_acc_arith = w_ovf ? sat16(r_acc[15]) : w_sum;
`else
    assign w_acc_arith = w_sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_EMPTY;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_next = S_FULL;
            S_FULL:  if (out_ready && !w_accept) w_state_next = S_EMPTY;
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (r_state == S_FULL);
        in_ready  = (r_state == S_EMPTY) || out_ready;
    end

    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc        <= 16'h0000;
            r_cout       <= 1'b0;
            r_ovf        <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_zero       <= 1'b1;
            r_count      <= 8'h00;
        end else if (w_accept) begin
            case (Op)
                OP_ADD, OP_SUB: begin
                    r_acc        <= w_acc_arith;
                    r_zero       <= (w_acc_arith == 16'h0000);
                    r_cout       <= w_cout;
                    r_ovf        <= w_ovf;
                    r_ovf_sticky <= r_ovf_sticky | w_ovf;
                    if (r_count != 8'hFF) r_count <= r_count + 8'd1;
                end
                OP_LOAD: begin
                    r_acc        <= In;
                    r_zero       <= (In == 16'h0000);
                    r_cout       <= 1'b0;
                    r_ovf        <= 1'b0;
                    r_ovf_sticky <= 1'b0;
                    r_count      <= 8'h00;
                end
                OP_CLR: begin
                    r_acc        <= 16'h0000;
                    r_zero       <= 1'b1;
                    r_cout       <= 1'b0;
                    r_ovf        <= 1'b0;
                    r_ovf_sticky <= 1'b0;
                    r_count      <= 8'h00;
                end
                default: ;
            endcase
        end
    end

    assign Acc       = r_acc;
    assign Cout      = r_cout;
    assign Ovf       = r_ovf;
    assign OvfSticky = r_ovf_sticky;
    assign Zero      = r_zero;
    assign Count     = r_count;
endmodule

// File: tb/tb_acc16_seq.sv
// Scoreboard bench for acc16_seq: an arithmetic model pushes expected results on each accept.
module tb_acc16_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] In;
    logic [1:0]  Op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Acc;
    logic        Cout;
    logic        Ovf;
    logic        OvfSticky;
    logic        Zero;
    logic [7:0]  Count;

    int n_checks = 0;
    int n_fail   = 0;

    // expected {Acc, Cout, Ovf, OvfSticky, Zero, Count}
    logic [27:0] sb_q[$];

    logic [15:0] m_acc;
    logic        m_cout, m_ovf, m_stk;
    logic [7:0]  m_cnt;

    acc16_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .In        (In),
        .Op        (Op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Acc       (Acc),
        .Cout      (Cout),
        .Ovf       (Ovf),
        .OvfSticky (OvfSticky),
        .Zero      (Zero),
        .Count     (Count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_acc = 16'h0; m_cout = 1'b0; m_ovf = 1'b0; m_stk = 1'b0; m_cnt = 8'h0;
        sb_q.delete();
    endtask

    task automatic model_apply(input logic [1:0] op, input logic [15:0] v);
        int a, b, r;
        logic [16:0] u;
        a = int'($signed(m_acc));
        b = int'($signed(v));
        if (op >= 2'd2) begin
            m_acc = (op == 2'd2) ? v : 16'h0;
            m_cout = 1'b0; m_ovf = 1'b0; m_stk = 1'b0; m_cnt = 8'h0;
        end else begin
            r = (op == 2'd0) ? a + b : a - b;
            u = (op == 2'd0) ? {1'b0, m_acc} + {1'b0, v} : {1'b0, m_acc} + {1'b0, ~v} + 17'd1;
            m_cout = u[16];
            m_ovf  = (r > 32767) || (r < -32768);
            m_stk  = m_stk | m_ovf;
            if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
`ifdef ACC16_SAT_EN
            m_acc = m_ovf ? ((r > 0) ? 16'h7FFF : 16'h8000) : u[15:0];
`else
            m_acc = u[15:0];
`endif
        end
        sb_q.push_back({m_acc, m_cout, m_ovf, m_stk, (m_acc == 16'h0), m_cnt});
    endtask

    // Presents one operand, waits (bounded) for acceptance, returns observed and expected output.
    task automatic do_op(input logic [1:0] op, input logic [15:0] v,
                         output logic [28:0] got, output logic [28:0] exp);
        int w;
        @(negedge clk);
        in_valid = 1'b1; Op = op; In = v;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            got = 'x;
            exp = '0;
            return;
        end
        @(posedge clk);
        model_apply(op, v);
        #1;
        got = {out_valid, Acc, Cout, Ovf, OvfSticky, Zero, Count};
        exp = {1'b1, sb_q.pop_front()};
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; In = 16'h0; Op = 2'b00; out_ready = 1'b1;
        model_reset();
        #12;
        n_checks++;
        if ({out_valid, Acc, Cout, Ovf, OvfSticky, Zero, Count} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0}) begin
            n_fail++;
            $display("FAIL reset_values got=%h exp=%h", {out_valid, Acc, Cout, Ovf, OvfSticky, Zero, Count},
                     {1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0});
        end
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_add();
        logic [28:0] got, exp;
        do_op(2'b10, 16'h0005, got, exp);
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL add_load got=%h exp=%h", got, exp); end
        do_op(2'b00, 16'h0003, got, exp);
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL add_result got=%h exp=%h", got, exp); end
        n_checks++;
        if ({Acc, Cout, Ovf, Count, Zero} !== {16'h0008, 1'b0, 1'b0, 8'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_const got=%h exp=%h", {Acc, Cout, Ovf, Count, Zero}, {16'h0008, 1'b0, 1'b0, 8'd1, 1'b0});
        end
    endtask

    task automatic test_overflow();
        logic [28:0] got, exp;
        do_op(2'b10, 16'h7FFF, got, exp);
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL ovf_load got=%h exp=%h", got, exp); end
        do_op(2'b00, 16'h0001, got, exp);
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL ovf_add got=%h exp=%h", got, exp); end
`ifdef ACC16_SAT_EN
        n_checks++;
        if ({Acc, Ovf, OvfSticky} !== {16'h7FFF, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL ovf_const got=%h exp=%h", {Acc, Ovf, OvfSticky}, {16'h7FFF, 1'b1, 1'b1});
        end
`else
        n_checks++;
        if ({Acc, Ovf, OvfSticky} !== {16'h8000, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL ovf_const got=%h exp=%h", {Acc, Ovf, OvfSticky}, {16'h8000, 1'b1, 1'b1});
        end
`endif
        // negative overflow direction
        do_op(2'b10, 16'h8000, got, exp);
        do_op(2'b01, 16'h0001, got, exp);
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL ovf_neg got=%h exp=%h", got, exp); end
    endtask

    task automatic test_sub();
        logic [28:0] got, exp;
        do_op(2'b10, 16'h0003, got, exp);
        do_op(2'b01, 16'h0003, got, exp);
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL sub_zero got=%h exp=%h", got, exp); end
        n_checks++;
        if ({Acc, Zero, Cout} !== {16'h0000, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL sub_zero_const got=%h exp=%h", {Acc, Zero, Cout}, {16'h0000, 1'b1, 1'b1});
        end
        do_op(2'b01, 16'h0001, got, exp);
        n_checks++;
        if ({Acc, Cout, Ovf} !== {16'hFFFF, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL sub_borrow got=%h exp=%h", {Acc, Cout, Ovf}, {16'hFFFF, 1'b0, 1'b0});
        end
    endtask

    task automatic test_random_mix();
        logic [28:0] got, exp;
        for (int i = 0; i < 40; i++) begin
            do_op(2'($urandom_range(0, 3)), 16'($urandom), got, exp);
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL random_op%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_backpressure();
        logic [28:0] got, exp;
        logic [15:0] hold;
        idle();
        @(negedge clk);
        out_ready = 1'b0;
        do_op(2'b00, 16'h0010, got, exp);
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL bp_first got=%h exp=%h", got, exp); end
        hold = Acc;
        @(negedge clk);
        in_valid = 1'b1; Op = 2'b00; In = 16'h0020;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({in_ready, out_valid, Acc} !== {1'b0, 1'b1, hold}) begin
                n_fail++; $display("FAIL bp_hold%0d got=%h exp=%h", i, {in_ready, out_valid, Acc}, {1'b0, 1'b1, hold});
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        @(posedge clk);
        model_apply(2'b00, 16'h0020);
        #1;
        exp = {1'b1, sb_q.pop_front()};
        got = {out_valid, Acc, Cout, Ovf, OvfSticky, Zero, Count};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL bp_release got=%h exp=%h", got, exp); end
        idle();
    endtask

    task automatic test_count_saturate();
        logic [28:0] got, exp;
        int bad;
        do_op(2'b11, 16'h0000, got, exp);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            do_op(2'b00, 16'h0001, got, exp);
            if (got !== exp) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL count_stream mismatched_ops=%0d exp=0", bad); end
        n_checks++;
        if ({Count, Acc} !== {8'd255, 16'h012C}) begin
            n_fail++; $display("FAIL count_sat got=%h exp=%h", {Count, Acc}, {8'd255, 16'h012C});
        end
        do_op(2'b11, 16'h1234, got, exp);
        n_checks++;
        if ({Count, OvfSticky, Acc, Zero} !== {8'd0, 1'b0, 16'h0, 1'b1}) begin
            n_fail++; $display("FAIL count_clr got=%h exp=%h", {Count, OvfSticky, Acc, Zero}, {8'd0, 1'b0, 16'h0, 1'b1});
        end
    endtask

    task automatic test_reset_mid();
        logic [28:0] got, exp;
        do_op(2'b10, 16'h7FFF, got, exp);
        @(negedge clk);
        out_ready = 1'b0;
        do_op(2'b00, 16'h0001, got, exp);
        @(negedge clk);
        in_valid = 1'b1; Op = 2'b10; In = 16'h1234;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, Acc, Cout, Ovf, OvfSticky, Zero, Count} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0}) begin
            n_fail++;
            $display("FAIL rst_async got=%h exp=%h", {out_valid, Acc, Cout, Ovf, OvfSticky, Zero, Count},
                     {1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0});
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if ({in_ready, out_valid, Acc} !== {1'b1, 1'b0, 16'h0}) begin
            n_fail++; $display("FAIL rst_release got=%h exp=%h", {in_ready, out_valid, Acc}, {1'b1, 1'b0, 16'h0});
        end
        do_op(2'b00, 16'h0007, got, exp);
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL rst_resume got=%h exp=%h", got, exp); end
        idle();
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_sub();
        test_random_mix();
        test_backpressure();
        test_count_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
